// File: rtl/imem_fetch_pkg.sv
// Shared constants and types for the instruction-memory fetch port.
// Fault bit positions and the NOP used for faulted fetches live here.
package imem_fetch_pkg;

    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam int          FAULT_MISALIGN = 0;
    localparam int          FAULT_RANGE    = 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [1:0]  fault;
    } fetch_word_t;

    function automatic logic [1:0] fault_code(input logic misaligned, input logic out_of_range);
        logic [1:0] f;
        f                 = '0;
        f[FAULT_MISALIGN] = misaligned;
        f[FAULT_RANGE]    = out_of_range;
        return f;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count.
// Depth need not be a power of two; pointers wrap explicitly.
module imem_rsp_fifo #(
    parameter int DEPTH_F = 2,
    parameter int WIDTH   = 8,
    localparam int PTR_W  = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1,
    localparam int CNT_W  = $clog2(DEPTH_F + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] storage [DEPTH_F];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != CNT_W'(DEPTH_F));
    assign do_pop   = pop && (count != '0);
    assign valid    = (count != '0);
    assign pop_data = storage[rd_ptr];

    // NOTE: storage holds only payload qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH_F - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH_F - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a pipelined valid/ready fetch port, program-load port,
// fault reporting, flush, and a response buffer sized to absorb full backpressure.
module imem_fetch_port
    import imem_fetch_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_fault,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              busy
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int FIFO_D  = RD_LAT + 1;
    localparam int CNT_W   = $clog2(FIFO_D + 1);
    localparam int WORD_W  = $bits(fetch_word_t);
    localparam int ENTRY_W = ADDR_W + WORD_W;

    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic              req_mis;
    logic              req_oor;
    logic              ld_ok;
    logic              fire;
    fetch_word_t       acc_word;
    logic [ENTRY_W-1:0] acc_entry;
    logic              push_valid;
    logic [ENTRY_W-1:0] push_data;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              fifo_valid;
    logic [ENTRY_W-1:0] fifo_data;
    fetch_word_t       head_word;

    assign req_idx = req_addr[IDX_W+1:2];
    assign req_mis = |req_addr[1:0];
    assign req_oor = |req_addr[ADDR_W-1:IDX_W+2];
    assign ld_idx  = ld_addr[IDX_W+1:2];
    assign ld_ok   = ~|ld_addr[1:0] && ~|ld_addr[ADDR_W-1:IDX_W+2];

    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // NOTE: every field gets a value on every path, so no latch can be inferred.
    always_comb begin
        acc_word.fault = fault_code(req_mis, req_oor);
        acc_word.inst  = (req_mis || req_oor) ? NOP_INST : mem[req_idx];
    end

    assign acc_entry = {req_addr, acc_word};

    // Total outstanding never exceeds the FIFO depth, so a stalled consumer cannot lose data.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    assign req_ready = !rst && !flush && !ld_en && (occupancy < (CNT_W + 1)'(FIFO_D));
    assign fire      = req_valid && req_ready;

    // The FIFO write itself is the last latency stage, so only RD_LAT-1 registers precede it.
    generate
        if (RD_LAT == 1) begin : g_direct
            assign push_valid = fire;
            assign push_data  = acc_entry;
            assign inflight   = '0;
        end else begin : g_pipe
            logic [RD_LAT-2:0]  pipe_valid;
            logic [ENTRY_W-1:0] pipe_data [RD_LAT-1];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= fire;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pipe_data[0] <= acc_entry;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    inflight = inflight + CNT_W'(pipe_valid[i]);
                end
            end

            assign push_valid = pipe_valid[RD_LAT-2];
            assign push_data  = pipe_data[RD_LAT-2];
        end
    endgenerate

    imem_rsp_fifo #(
        .DEPTH_F (FIFO_D),
        .WIDTH   (ENTRY_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (rsp_ready),
        .pop_data  (fifo_data),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    // Payload is forced to zero when no response is presented.
    assign head_word = fetch_word_t'(fifo_data[WORD_W-1:0]);
    assign rsp_valid = fifo_valid;
    assign rsp_inst  = fifo_valid ? head_word.inst : '0;
    assign rsp_fault = fifo_valid ? head_word.fault : '0;
    assign rsp_addr  = fifo_valid ? fifo_data[ENTRY_W-1 -: ADDR_W] : '0;
    assign busy      = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Randomised scoreboard bench for imem_fetch_port: the driver queues expected
// responses on accept, an independent negedge monitor pops and compares them.
module tb_imem_fetch_port;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int RD_LAT = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [1:0]  fault;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_pop = -100;
    bit          front_seen = 0;
    bit          clear_pending = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [DEPTH];

    imem_fetch_port #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: word-addressed array, faults from plain address arithmetic.
    function automatic exp_t model(input logic [31:0] a, input int c);
        exp_t e;
        logic mis;
        logic oor;
        mis     = (a % 4) != 0;
        oor     = a >= 32'(DEPTH * 4);
        e.addr  = a;
        e.fault = {oor, mis};
        e.inst  = (mis || oor) ? NOP : ref_mem[int'(a / 4)];
        e.acc   = c;
        return e;
    endfunction

    task automatic drive(input logic r, input logic rv, input logic [31:0] a, input logic rr,
                         input logic fl, input logic le, input logic [31:0] la,
                         input logic [31:0] ld, output logic acc);
        logic exp_ready;
        @(posedge clk);
        if (clear_pending) begin
            exp_q.delete();
            front_seen    = 0;
            clear_pending = 0;
        end
        #1;
        rst = r; req_valid = rv; req_addr = a; rsp_ready = rr;
        flush = fl; ld_en = le; ld_addr = la; ld_data = ld;
        #1;
        exp_ready = !r && !fl && !le && (exp_q.size() < RD_LAT + 1);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (!r) check("busy", 64'(busy), 64'(exp_q.size() != 0));
        acc = rv && req_ready;
        if (acc) exp_q.push_back(model(a, cyc));
        if (le && (la % 4) == 0 && la < 32'(DEPTH * 4)) ref_mem[int'(la / 4)] = ld;
        if (r || fl) clear_pending = 1;
    endtask

    task automatic idle(input logic rr);
        logic a;
        drive(1'b0, 1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0, a);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic rr, output logic acc);
        drive(1'b0, 1'b1, addr, rr, 1'b0, 1'b0, 32'h0, 32'h0, acc);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        logic a;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, addr, data, a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_inst"},  64'(rsp_inst),  64'(0));
        check({tag, "_rsp_addr"},  64'(rsp_addr),  64'(0));
        check({tag, "_rsp_fault"}, 64'(rsp_fault), 64'(0));
    endtask

    // Monitor: compares the presented response with the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_stray", 64'(rsp_valid), 64'(0));
            end else begin
                mon_e = exp_q[0];
                if (!front_seen) begin
                    int t;
                    t = mon_e.acc + RD_LAT;
                    if (last_pop + 1 > t) t = last_pop + 1;
                    check("rsp_latency", 64'(cyc), 64'(t));
                    front_seen = 1;
                end
                check("rsp_inst",  64'(rsp_inst),  64'(mon_e.inst));
                check("rsp_addr",  64'(rsp_addr),  64'(mon_e.addr));
                check("rsp_fault", 64'(rsp_fault), 64'(mon_e.fault));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    front_seen = 0;
                    last_pop   = cyc;
                end
            end
        end
    end

    initial begin
        logic acc;
        int   n_acc;
        int   idx;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;

        // Reset, then verify idle output values.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, acc);
        idle(1'b1);
        check_quiet("reset");

        // Program image: words 0..12 hold their index, the rest random.
        for (int i = 0; i < DEPTH; i++) load(32'(i * 4), (i < 13) ? 32'(i) : $urandom);
        load(32'h22, 32'h1111_1111);
        load(32'h100, 32'h2222_2222);

        // Back-to-back fetches with a ready consumer.
        fetch(32'h0, 1'b1, acc);
        fetch(32'h4, 1'b1, acc);
        fetch(32'h8, 1'b1, acc);
        drain();

        // Full backpressure: only RD_LAT+1 fetches may be accepted.
        n_acc = 0;
        idx   = 4;
        for (int i = 0; i < 10; i++) begin
            fetch(32'(idx * 4), 1'b0, acc);
            if (acc) begin
                n_acc++;
                idx++;
            end
        end
        check("stream_accepts", 64'(n_acc), 64'(RD_LAT + 1));
        drain();

        // Faulted fetches, and a fetch of the word a rejected load aimed at.
        fetch(32'h6, 1'b1, acc);
        fetch(32'h100, 1'b1, acc);
        fetch(32'h20, 1'b1, acc);
        fetch(32'h8000_0000, 1'b1, acc);
        drain();

        // Flush with three fetches outstanding; the request beside it is refused.
        fetch(32'h4, 1'b1, acc);
        fetch(32'h8, 1'b1, acc);
        fetch(32'hC, 1'b1, acc);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, acc);
        check("flush_req_refused", 64'(acc), 64'(0));
        idle(1'b1);
        check("flush_rsp_valid", 64'(rsp_valid), 64'(0));
        check("flush_busy", 64'(busy), 64'(0));
        idle(1'b1);

        // Load then fetch; a fetch accepted just before a load sees the old word.
        load(32'h10, 32'hDEAD_BEEF);
        fetch(32'h10, 1'b1, acc);
        load(32'h10, 32'hCAFE_F00D);
        fetch(32'h10, 1'b1, acc);
        drain();

        // Reset with two buffered and one in flight; memory must survive.
        fetch(32'h10, 1'b0, acc);
        fetch(32'h14, 1'b0, acc);
        fetch(32'h18, 1'b0, acc);
        idle(1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, acc);
        idle(1'b1);
        check_quiet("midrst");
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        fetch(32'h10, 1'b1, acc);
        drain();

        // Random traffic: backpressure, faults, flushes and loads interleaved.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] la;
            a  = ($urandom_range(0, 9) == 0) ? ($urandom & 32'h0000_01FF)
                                              : 32'($urandom_range(0, DEPTH - 1)) * 4;
            la = 32'($urandom_range(0, DEPTH + 7)) * 4 + 32'(($urandom_range(0, 7) == 0) ? 2 : 0);
            drive(1'b0, 1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 29) == 0),
                  la, $urandom, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
